ar_alloc_ctrl: RTL
==================

Name: ar_alloc_ctrl

Overview:
- Sequences the AXI read-address path through the ROB tag allocator.
- Accepts one AR beat from upstream and holds it. Requests a unique ID (UID) from the allocator tag map, then issues the AR downstream with ARID replaced by that UID.
- Sits between the upstream AR slave port and the downstream memory-side AR master port, and owns the allocator's alloc interface. The free interface is not driven by this block.

Parameters:
- ID_WIDTH, 4: width of the original (upstream) ARID.
- UID_W, 8: width of the allocator UID; it is also the downstream ARID width.
- ADDR_WIDTH, 32: ARADDR width.
- LEN_WIDTH, 8: ARLEN width.
- STALL_CNT_W, 16: width of the allocation-stall counter.
- WATCHDOG_CYCLES, 255: threshold for the optional watchdog (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- s_arvalid  in  1  upstream AR valid.
- s_arready  out  1  upstream AR ready.
- s_arid  in  ID_WIDTH  upstream original ID.
- s_araddr  in  ADDR_WIDTH  upstream address.
- s_arlen  in  LEN_WIDTH  upstream burst length.
- m_arvalid  out  1  downstream AR valid.
- m_arready  in  1  downstream AR ready.
- m_arid  out  UID_W  remapped ID (UID).
- m_araddr  out  ADDR_WIDTH  held address.
- m_arlen  out  LEN_WIDTH  held length.
- alloc_req  out  1  allocation request to the tag map.
- alloc_orig_id  out  ID_WIDTH  original ID presented to the tag map.
- alloc_gnt  in  1  tag map grant; combinational, same cycle as alloc_req.
- alloc_uid  in  UID_W  granted UID; valid only while alloc_gnt=1.
- busy  out  1  high whenever the FSM is not in IDLE.
- stall_cnt  out  STALL_CNT_W  saturating count of ALLOC cycles without a grant.
- issued_cnt  out  16  wrapping count of completed downstream AR handshakes.
- alloc_timeout  out  1  watchdog flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - FSM goes to IDLE.
  - The holding registers (id/addr/len/uid) are cleared to 0.
  - stall_cnt, issued_cnt and alloc_timeout are cleared to 0.
  - Resulting outputs: s_arready=1, m_arvalid=0, alloc_req=0, busy=0, m_arid/m_araddr/m_arlen=0.
- FSM states are IDLE, ALLOC and ISSUE.
- IDLE:
  - Drives s_arready=1, alloc_req=0, m_arvalid=0.
  - On s_arvalid&s_arready, captures s_arid/s_araddr/s_arlen and moves to ALLOC.
- ALLOC:
  - Drives s_arready=0, alloc_req=1, alloc_orig_id=held id.
  - If alloc_gnt=1: captures alloc_uid into the uid register and moves to ISSUE.
  - If alloc_gnt=0: stays in ALLOC; stall_cnt increments and saturates at all-ones.
  - alloc_req stays continuously high until granted. A grant is consumed exactly once.
- ISSUE:
  - Drives m_arvalid=1, m_arid=held uid, m_araddr/m_arlen=held values.
  - The outputs stay stable while m_arvalid=1 and m_arready=0 (AXI rule).
  - On m_arready=1: moves to IDLE and issued_cnt increments, wrapping from 0xFFFF to 0.
- Latency and throughput:
  - With an immediate grant and m_arready=1: upstream handshake in cycle 0, grant in cycle 1, downstream handshake in cycle 2.
  - Peak throughput is 1 AR per 3 cycles.
- Signal rules:
  - alloc_gnt is ignored outside ALLOC.
  - m_arready is ignored outside ISSUE.
  - s_arvalid is ignored outside IDLE.
- Reset mid-operation:
  - A held request is discarded.
  - A grant arriving in the same cycle as rst_n=0 is not consumed. The tag map shares this reset, so no UID leaks.
- stall_cnt is cumulative across requests. It is cleared only by reset.

Optional Feature:
- Macro: AR_ALLOC_WATCHDOG_EN.
- When defined:
  - An internal counter, cleared on each entry to ALLOC, counts consecutive no-grant ALLOC cycles.
  - When the count reaches WATCHDOG_CYCLES, alloc_timeout is set.
  - alloc_timeout is sticky until reset. The FSM keeps requesting.
- When undefined: alloc_timeout is tied to 0 and no counter logic is generated.

Test Plan:
- Single AR with immediate grant:
  - Stimulus: s_arid=0x3, s_araddr=0x1000, s_arlen=7, alloc_gnt=1 with alloc_uid=0x12, m_arready=1.
  - Required: m_arvalid in cycle 2 with m_arid=0x12, m_araddr=0x1000, m_arlen=7; issued_cnt=1; stall_cnt=0.
- Grant delay:
  - Stimulus: alloc_gnt is held 0 for 5 ALLOC cycles, then 1.
  - Required: alloc_req is high for 6 consecutive cycles; stall_cnt=5; exactly one ISSUE.
- Downstream backpressure:
  - Stimulus: m_arready=0 for 4 cycles in ISSUE.
  - Required: m_arvalid/m_arid/m_araddr stay stable; s_arready=0 throughout; IDLE entered the cycle after m_arready=1.
- Reset during ALLOC:
  - Stimulus: rst_n=0 in the same cycle as alloc_gnt=1.
  - Required: next cycle is IDLE with s_arready=1, m_arvalid=0, counters 0; no downstream AR is issued.
- Back-to-back stream:
  - Stimulus: 65537 ARs with immediate grant and m_arready=1.
  - Required: issued_cnt wraps to 1; s_arready is high once every 3 cycles.
- AR_ALLOC_WATCHDOG_EN defined, WATCHDOG_CYCLES=4:
  - Stimulus: no grant for 4 cycles.
  - Required: alloc_timeout=1 and remains 1 after the grant arrives; alloc_timeout=0 in the undefined build.

Source files
------------

// File: rtl/ar_alloc_ctrl.sv
// ar_alloc_ctrl: holds one upstream AR, obtains a UID from the ROB tag map, issues the AR downstream with ARID=UID
// Ports: s_ar* upstream AR slave; m_ar* downstream AR master (m_arid carries the UID);
//        alloc_req/alloc_orig_id/alloc_gnt/alloc_uid allocator alloc interface;
//        busy (not IDLE), stall_cnt (saturating no-grant ALLOC cycles), issued_cnt (wrapping downstream handshakes),
//        alloc_timeout (watchdog flag, only active when AR_ALLOC_WATCHDOG_EN is defined, otherwise tied 0)
module ar_alloc_ctrl #(
  parameter int ID_WIDTH        = 4,
  parameter int UID_W           = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 8,
  parameter int STALL_CNT_W     = 16,
  parameter int WATCHDOG_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  input  logic [ID_WIDTH-1:0]    s_arid,
  input  logic [ADDR_WIDTH-1:0]  s_araddr,
  input  logic [LEN_WIDTH-1:0]   s_arlen,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  output logic [UID_W-1:0]       m_arid,
  output logic [ADDR_WIDTH-1:0]  m_araddr,
  output logic [LEN_WIDTH-1:0]   m_arlen,
  output logic                   alloc_req,
  output logic [ID_WIDTH-1:0]    alloc_orig_id,
  input  logic                   alloc_gnt,
  input  logic [UID_W-1:0]       alloc_uid,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [15:0]            issued_cnt,
  output logic                   alloc_timeout
);
  typedef enum logic [1:0] {IDLE, ALLOC, ISSUE} state_t;
  state_t state;
  logic [ID_WIDTH-1:0] id_q;
  if (WATCHDOG_CYCLES < 1) begin : g_bad_wd
    $error("WATCHDOG_CYCLES must be >= 1");
  end
  assign alloc_orig_id = id_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_arready  <= 1'b1;
      m_arvalid  <= 1'b0;
      alloc_req  <= 1'b0;
      busy       <= 1'b0;
      id_q       <= '0;
      m_araddr   <= '0;
      m_arlen    <= '0;
      m_arid     <= '0;
      stall_cnt  <= '0;
      issued_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (s_arvalid) begin
          state     <= ALLOC;
          s_arready <= 1'b0;
          alloc_req <= 1'b1;
          busy      <= 1'b1;
          id_q      <= s_arid;
          m_araddr  <= s_araddr;
          m_arlen   <= s_arlen;
        end
        ALLOC: if (alloc_gnt) begin
          state     <= ISSUE;
          alloc_req <= 1'b0;
          m_arvalid <= 1'b1;
          m_arid    <= alloc_uid;
        end else if (~&stall_cnt) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
        ISSUE: if (m_arready) begin
          state      <= IDLE;
          m_arvalid  <= 1'b0;
          s_arready  <= 1'b1;
          busy       <= 1'b0;
          issued_cnt <= issued_cnt + 1'b1;
        end
        default: begin
          state     <= IDLE;
          s_arready <= 1'b1;
          m_arvalid <= 1'b0;
          alloc_req <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
`ifdef AR_ALLOC_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt        <= '0;
      alloc_timeout <= 1'b0;
    end else if (state == IDLE && s_arvalid) begin
      wd_cnt <= '0;
    end else if (state == ALLOC && !alloc_gnt) begin
      if (wd_cnt != WD_W'(WATCHDOG_CYCLES)) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1)) alloc_timeout <= 1'b1;
    end
  end
`else
  assign alloc_timeout = 1'b0;
`endif
endmodule
